// File: rtl/tty_writer.sv
// Glass-TTY character engine: turns a byte stream into port-B writes of the text
// frame store, owning the cursor, wrap, scroll-by-copy and screen clear.
module tty_writer #(
  parameter int COLS           = 128,
  parameter int ROWS           = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk_data,
  input  logic        irst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [63:0] ram_dinb,
  output logic [10:0] ram_addrb,
  output logic [7:0]  ram_web,
  output logic        ram_enb,
  input  logic [63:0] ram_doutb,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, WR, CLR, SRD, SWAIT, SWR, SCLR} state_t;

  localparam logic [10:0] ROW_WORDS   = 11'(COLS / 8);
  localparam logic [10:0] LAST_W      = 11'(ROWS * (COLS / 8) - 1);
  localparam logic [10:0] LAST_ROW_W0 = 11'((ROWS - 1) * (COLS / 8));
  localparam logic [5:0]  ROW_LAST    = 6'(ROWS - 1);
  localparam logic [63:0] SPACES      = {8{8'h20}};
  // A single-row screen has nothing to copy, so scrolling is just the row clear.
  localparam state_t      SCR_FIRST   = (ROWS > 1) ? SRD : SCLR;
  localparam logic [10:0] SCR_CNT0    = (ROWS > 1) ? ROW_WORDS : 11'd0;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic        pend_clr_q, pend_clr_d;
  logic        scroll_pend_q, scroll_pend_d;
  logic        rx_ready_q, rx_ready_d;
  logic        busy_q, busy_d;
  logic        enb_q, enb_d;
  logic [7:0]  web_q, web_d;
  logic [10:0] addr_q, addr_d;
  logic [63:0] dinb_q, dinb_d;
  logic        accept;
  logic        nl;
  logic [7:0]  tab_col;

  assign accept = rx_valid & rx_ready_q;

  always_ff @(posedge clk_data) begin
    if (irst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      pend_clr_q    <= CLEAR_ON_RESET;
      scroll_pend_q <= 1'b0;
      rx_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      enb_q         <= 1'b0;
      web_q         <= '0;
      addr_q        <= '0;
      dinb_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      pend_clr_q    <= pend_clr_d;
      scroll_pend_q <= scroll_pend_d;
      rx_ready_q    <= rx_ready_d;
      busy_q        <= busy_d;
      enb_q         <= enb_d;
      web_q         <= web_d;
      addr_q        <= addr_d;
      dinb_q        <= dinb_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    col_d         = col_q;
    row_d         = row_q;
    pend_clr_d    = pend_clr_q;
    scroll_pend_d = scroll_pend_q;
    nl            = 1'b0;
    tab_col       = {1'b0, col_q | 7'd7} + 8'd1;
    case (state_q)
      IDLE: begin
        if (pend_clr_q) begin
          state_d    = CLR;
          cnt_d      = '0;
          pend_clr_d = 1'b0;
        end else if (accept) begin
          if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
            state_d = WR;
            col_d   = col_q + 7'd1;
            // Wrap newline: the row moves now, a scroll waits until the write is done.
            if (col_q == 7'd127) begin
              if (row_q < ROW_LAST) row_d = row_q + 6'd1;
              else                  scroll_pend_d = 1'b1;
            end
          end else begin
            case (rx_data)
              8'h0D: col_d = '0;
              8'h0A: begin col_d = '0; nl = 1'b1; end
              8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
              8'h09: begin
                if (tab_col[7]) begin col_d = '0; nl = 1'b1; end
                else            col_d = tab_col[6:0];
              end
              8'h0C: begin state_d = CLR; cnt_d = '0; end
              default: ;
            endcase
            if (nl) begin
              if (row_q < ROW_LAST) row_d = row_q + 6'd1;
              else begin state_d = SCR_FIRST; cnt_d = SCR_CNT0; end
            end
          end
        end
      end
      WR: begin
        if (scroll_pend_q) begin
          state_d       = SCR_FIRST;
          cnt_d         = SCR_CNT0;
          scroll_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CLR: begin
        if (cnt_q == LAST_W) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      SRD:   state_d = SWAIT;
      SWAIT: state_d = SWR;
      SWR: begin
        if (cnt_q == LAST_W) begin
          state_d = SCLR;
          cnt_d   = LAST_ROW_W0;
        end else begin
          state_d = SRD;
          cnt_d   = cnt_q + 11'd1;
        end
      end
      SCLR: begin
        if (cnt_q == LAST_W) state_d = IDLE;
        else                 cnt_d   = cnt_q + 11'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so each RAM access is
  // presented for exactly the cycle its state occupies.
  always_comb begin
    rx_ready_d = (state_d == IDLE) && !accept;
    busy_d     = (state_d != IDLE);
    enb_d      = 1'b0;
    web_d      = '0;
    addr_d     = '0;
    dinb_d     = '0;
    case (state_d)
      WR: begin
        enb_d  = 1'b1;
        web_d  = 8'd1 << col_q[2:0];
        addr_d = {1'b0, row_q, col_q[6:3]};
        dinb_d = {8{rx_data}};
      end
      CLR, SCLR: begin
        enb_d  = 1'b1;
        web_d  = 8'hFF;
        addr_d = cnt_d;
        dinb_d = SPACES;
      end
      SRD: begin
        enb_d  = 1'b1;
        addr_d = cnt_d;
      end
      SWR: begin
        enb_d  = 1'b1;
        web_d  = 8'hFF;
        addr_d = cnt_d - ROW_WORDS;
        dinb_d = ram_doutb;
      end
      default: ;
    endcase
  end

  assign rx_ready   = rx_ready_q;
  assign busy       = busy_q;
  assign ram_enb    = enb_q;
  assign ram_web    = web_q;
  assign ram_addrb  = addr_q;
  assign ram_dinb   = dinb_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_tty_writer.sv
// Bench for tty_writer: RAM model on port B plus a character-grid reference model
// of the screen and cursor, driven by directed and random byte streams.
module tb_tty_writer;

  localparam int ROWS = 32;
  localparam logic [63:0] SPACES = {8{8'h20}};

  logic        clk_data;
  logic        irst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] ram_dinb;
  logic [10:0] ram_addrb;
  logic [7:0]  ram_web;
  logic        ram_enb;
  logic [63:0] ram_doutb;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  tty_writer #(.COLS(128), .ROWS(ROWS), .CLEAR_ON_RESET(1'b1)) dut (
    .clk_data(clk_data), .irst(irst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ram_dinb(ram_dinb), .ram_addrb(ram_addrb),
    .ram_web(ram_web), .ram_enb(ram_enb), .ram_doutb(ram_doutb),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  initial clk_data = 1'b0;
  always #5 clk_data = ~clk_data;

  typedef struct packed {
    logic [10:0] a;
    logic [7:0]  w;
    logic [63:0] d;
  } wr_t;

  logic [63:0] mem [0:2047];
  wr_t         log_q[$];
  logic        pre_en;
  logic [10:0] pre_addr;
  logic [63:0] pre_data;

  initial ram_doutb = '0;
  always @(posedge clk_data) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (ram_enb) begin
      if (ram_web == 8'h00) ram_doutb <= mem[ram_addrb];
      else begin
        for (int i = 0; i < 8; i++)
          if (ram_web[i]) mem[ram_addrb][8*i +: 8] <= ram_dinb[8*i +: 8];
        log_q.push_back(wr_t'{a: ram_addrb, w: ram_web, d: ram_dinb});
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int low_cnt, busy_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a plain character grid plus cursor.
  logic [7:0] scr [0:ROWS-1][0:127];
  int mrow, mcol;

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < 128; c++) scr[r][c] = 8'h20;
    mrow = 0;
    mcol = 0;
  endfunction

  function automatic void model_nl();
    if (mrow < ROWS - 1) mrow++;
    else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < 128; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < 128; c++) scr[ROWS-1][c] = 8'h20;
    end
  endfunction

  function automatic void model_putc(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[mrow][mcol] = b;
      if (mcol == 127) begin mcol = 0; model_nl(); end
      else mcol++;
    end else begin
      case (b)
        8'h0D: mcol = 0;
        8'h0A: begin mcol = 0; model_nl(); end
        8'h08: if (mcol > 0) mcol--;
        8'h09: if ((mcol | 7) + 1 > 127) begin mcol = 0; model_nl(); end
               else mcol = (mcol | 7) + 1;
        8'h0C: model_clear();
        default: ;
      endcase
    end
  endfunction

  function automatic logic [63:0] model_word(input int w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = scr[w/16][(w%16)*8 + i];
    return r;
  endfunction

  task automatic compare_screen();
    for (int w = 0; w < ROWS*16; w++)
      check_eq($sformatf("word%0d", w), mem[w], model_word(w));
  endtask

  task automatic check_cursor(input string tag);
    check_eq({tag, "_col"}, 64'(cursor_col), 64'(mcol));
    check_eq({tag, "_row"}, 64'(cursor_row), 64'(mrow));
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk_data);
    while (!rx_ready && n < 4000) begin @(negedge clk_data); n++; end
    check_eq("rdy_wait", 64'(rx_ready), 64'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk_data);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    low_cnt  = 0;
    busy_cnt = 0;
    @(negedge clk_data);
    while (!rx_ready && low_cnt < 4000) begin
      low_cnt++;
      busy_cnt += int'(busy);
      @(negedge clk_data);
    end
    model_putc(b);
  endtask

  task automatic release_reset();
    int n, bad;
    log_q.delete();
    irst = 1'b0;
    n = 0;
    @(negedge clk_data);
    while (!rx_ready && n < 3000) begin n++; @(negedge clk_data); end
    check_eq("clr_rdy", 64'(rx_ready), 64'd1);
    check_eq("clr_cycles", 64'(n), 64'd512);
    check_eq("clr_writes", 64'(log_q.size()), 64'd512);
    bad = 0;
    foreach (log_q[i])
      if (log_q[i].a != 11'(i) || log_q[i].w != 8'hFF || log_q[i].d != SPACES) bad++;
    check_eq("clr_order", 64'(bad), 64'd0);
    model_clear();
    check_cursor("clr");
  endtask

  task automatic preload(input int w, input logic [63:0] d);
    @(negedge clk_data);
    pre_en = 1'b1; pre_addr = 11'(w); pre_data = d;
    @(negedge clk_data);
    pre_en = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int r;
    irst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    for (int w = 0; w < ROWS*16; w++) begin
      @(negedge clk_data);
      pre_en = 1'b1; pre_addr = 11'(w); pre_data = {$urandom, $urandom};
    end
    @(negedge clk_data);
    pre_en = 1'b0;

    check_eq("rst_enb",  64'(ram_enb),   64'd0);
    check_eq("rst_web",  64'(ram_web),   64'd0);
    check_eq("rst_addr", 64'(ram_addrb), 64'd0);
    check_eq("rst_dinb", ram_dinb,       64'd0);
    check_eq("rst_busy", 64'(busy),      64'd0);
    check_eq("rst_rdy",  64'(rx_ready),  64'd0);
    check_eq("rst_col",  64'(cursor_col), 64'd0);
    check_eq("rst_row",  64'(cursor_row), 64'd0);
    release_reset();
    compare_screen();

    // Single printable at column 5
    for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)));
    log_q.delete();
    send(8'h41);
    check_eq("A_nwr",  64'(log_q.size()), 64'd1);
    check_eq("A_addr", 64'(log_q[0].a), 64'd0);
    check_eq("A_web",  64'(log_q[0].w), 64'h20);
    check_eq("A_dinb", log_q[0].d, {8{8'h41}});
    check_eq("A_low",  64'(low_cnt), 64'd1);
    check_cursor("A");
    log_q.delete();
    send(8'h0D);
    check_eq("CR_nwr", 64'(log_q.size()), 64'd0);
    check_eq("CR_low", 64'(low_cnt), 64'd1);
    check_cursor("CR");

    // Full row of printables wraps to the next line
    send(8'h0C);
    log_q.delete();
    for (int i = 0; i < 128; i++) send(8'($urandom_range(32, 126)));
    check_eq("row_nwr",  64'(log_q.size()), 64'd128);
    check_eq("row_addr", 64'(log_q[127].a), 64'd15);
    check_eq("row_web",  64'(log_q[127].w), 64'h80);
    check_cursor("row");
    compare_screen();

    // Control codes
    for (int i = 0; i < 125; i++) send(8'($urandom_range(32, 126)));
    log_q.delete();
    send(8'h09);
    check_cursor("tab125");
    send(8'h0D);
    send(8'h08);
    check_cursor("bs0");
    send(8'h09);
    check_cursor("tab0");
    send(8'h07);
    check_eq("bel_low", 64'(low_cnt), 64'd1);
    check_cursor("bel");
    check_eq("ctl_nwr", 64'(log_q.size()), 64'd0);

    // Scroll from the last row
    send(8'h0C);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    preload(16, {8{8'h11}});
    for (int c = 0; c < 8; c++) scr[1][c] = 8'h11;
    log_q.delete();
    send(8'h0A);
    check_eq("scr_busy", 64'(busy_cnt), 64'd1504);
    check_eq("scr_nwr",  64'(log_q.size()), 64'd512);
    check_eq("scr_a0",   64'(log_q[0].a), 64'd0);
    check_eq("scr_d0",   log_q[0].d, {8{8'h11}});
    check_eq("scr_alast", 64'(log_q[511].a), 64'd511);
    check_cursor("scr");
    compare_screen();

    // Reset while the scroll sits in its wait state
    send(8'h0C);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    @(negedge clk_data);
    rx_data = 8'h0A; rx_valid = 1'b1;
    @(posedge clk_data);
    #1;
    rx_valid = 1'b0;
    @(negedge clk_data);
    check_eq("srd_enb", 64'(ram_enb), 64'd1);
    check_eq("srd_web", 64'(ram_web), 64'd0);
    @(posedge clk_data);
    @(negedge clk_data);
    irst = 1'b1;
    @(posedge clk_data);
    @(negedge clk_data);
    check_eq("abort_enb",  64'(ram_enb), 64'd0);
    check_eq("abort_col",  64'(cursor_col), 64'd0);
    check_eq("abort_row",  64'(cursor_row), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_rdy",  64'(rx_ready), 64'd0);
    @(negedge clk_data);
    release_reset();

    // Random stream starting near the bottom so scrolls happen
    for (int i = 0; i < ROWS - 4; i++) send(8'h0A);
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      b = 8'($urandom_range(32, 126));
      else if (r < 76) b = 8'h0D;
      else if (r < 81) b = 8'h0A;
      else if (r < 86) b = 8'h08;
      else if (r < 92) b = 8'h09;
      else begin
        b = 8'($urandom_range(0, 255));
        if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h09 ||
            b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h7F;
      end
      send(b);
      check_cursor("rnd");
    end
    compare_screen();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
